mem_dual_port: RTL
==================

// Module: mem_dual_port
// PURPOSE
//  Memory responder for the write/read memory interface: a 2^AW x DW register-file RAM.
//  It has one synchronous write port and one synchronous read port with a 1-cycle registered read.
//  It tracks which entries hold data, flags reads of never-written locations, and counts valid entries.
//  Sits under the memory stimulus driver; reused later as storage behind the FIFO/buffer blocks.
// PARAMETERS
//  AW     3  address width; DEPTH = 2**AW entries (8)
//  DW     6  data width
// PORTS
//  clk            in   1      rising-edge clock
//  RESET_L        in   1      reset, asynchronous, active-low
//  write          in   1      write enable, sampled on posedge clk
//  address_write  in   AW     write address
//  data           in   DW     write data
//  read           in   1      read enable, sampled on posedge clk
//  address_read   in   AW     read address
//  data_out       out  DW     read data, registered
//  valid_out      out  1      data_out carries a read result this cycle
//  rd_err         out  1      current read result targets a never-written entry
//  wr_count       out  AW+1   number of entries written since reset (0..DEPTH)
// BEHAVIOUR
//  Reset (RESET_L=0, async, no clock needed):
//   - all mem entries = 0, all written flags = 0
//   - data_out=0, valid_out=0, rd_err=0, wr_count=0
//   - on release, first active edge is the first posedge with RESET_L=1
//  Write, on posedge with write=1:
//   - mem[address_write] <= data; written[address_write] <= 1
//   - wr_count increments only if written[address_write] was 0, so rewrites do not count
//   - saturates at DEPTH by construction
//  Read, on posedge with read=1, latency 1:
//   - next cycle valid_out=1 and data_out=mem[address_read]
//   - if written[address_read]=0: data_out=0 and rd_err=1 for that cycle
//  No read, on posedge with read=0:
//   - valid_out=0, rd_err=0
//   - data_out holds its last value; it is not cleared
//  Simultaneous write and read:
//   - different addresses: independent; the read returns the old contents of address_read
//   - same address: write-first forwarding, so data_out=data (the new value)
//   - a same-address collision with an unwritten entry gives rd_err=0
//  Back-to-back:
//   - a read may follow a write to the same address on the next cycle and returns the new data
//   - full throughput is one write plus one read per cycle, with no stalls and no backpressure
//  Addresses: full AW-bit range is valid; no out-of-range case
//  Reset mid-operation: an in-flight read result is dropped; valid_out falls immediately with RESET_L
//  No X on outputs after reset, for any input sequence with known inputs
// TESTING
//  T1 sequential fill:
//   - reset, then write data 1..8 to addresses 0..7 on consecutive cycles
//   - wr_count steps 1..8
//  T2 sequential readback:
//   - after T1, read addresses 0..7 consecutively
//   - data_out=1..8, each one cycle after its request; valid_out=1 for 8 cycles, then 0
//  T3 concurrent different-address:
//   - write addr1=0xC with read addr2 -> data_out=0x3
//   - next cycle write addr5=0xB with read addr1 -> 0xC
//   - then read addr5 -> 0xB; wr_count stays 8
//  T4 same-address collision:
//   - write addr1=0x2A with read addr1 in the same cycle -> data_out=0x2A next cycle
//  T5 unwritten read:
//   - after reset, read addr3 -> data_out=0, valid_out=1, rd_err=1
//   - write addr3=0x11, then read -> 0x11 with rd_err=0
//  T6 async reset mid-read:
//   - assert RESET_L=0 between edges during T2 -> outputs zero immediately
//   - after release, all entries read back 0 with rd_err=1

Source files
------------

// File: rtl/mem_dual_port_if.sv
// Purpose: write/read memory interface bundle between a memory driver and
//          the mem_dual_port responder.
// Signals:
//   write, address_write, data : write request (driver -> memory)
//   read, address_read         : read request (driver -> memory)
//   data_out, valid_out        : registered read result (memory -> driver)
//   rd_err                     : read result targets a never-written entry
//   wr_count                   : number of distinct entries written since reset
interface mem_dual_port_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 6
);
  logic          write;
  logic [AW-1:0] address_write;
  logic [DW-1:0] data;
  logic          read;
  logic [AW-1:0] address_read;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          rd_err;
  logic [AW:0]   wr_count;

  // Driver side: issues requests, observes results.
  modport master (
    output write, address_write, data, read, address_read,
    input  data_out, valid_out, rd_err, wr_count
  );

  // Memory side: accepts requests, returns results.
  modport slave (
    input  write, address_write, data, read, address_read,
    output data_out, valid_out, rd_err, wr_count
  );
endinterface

// File: rtl/mem_dual_port.sv
// Purpose: 2^AW x DW register-file RAM with one synchronous write port and one
//          synchronous read port (1-cycle registered read). Tracks which entries
//          have been written, flags reads of never-written entries and counts
//          distinct written entries.
// Ports:
//   clk     : rising-edge clock
//   RESET_L : asynchronous active-low reset
//   bus     : mem_dual_port_if slave modport (requests in, registered results out)
module mem_dual_port #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 6
) (
  input  logic            clk,
  input  logic            RESET_L,
  mem_dual_port_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DW-1:0]    data_out_q;
  logic             valid_out_q;
  logic             rd_err_q;
  logic [CW-1:0]    wr_count_q;

  logic             same_addr_c;

  // A same-cycle write to the read address is forwarded to the read result.
  assign same_addr_c = bus.write && (bus.address_write == bus.address_read);

  // Storage, written flags and distinct-entry counter.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
      written_q  <= '0;
      wr_count_q <= '0;
    end else if (bus.write) begin
      mem_q[bus.address_write]     <= bus.data;
      written_q[bus.address_write] <= 1'b1;
      // Rewrites of an entry do not count, so this saturates at DEPTH.
      if (!written_q[bus.address_write]) begin
        wr_count_q <= wr_count_q + CW'(1);
      end
    end
  end

  // Registered read result; data_out holds its value on idle cycles.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else if (bus.read) begin
      valid_out_q <= 1'b1;
      if (same_addr_c) begin
        data_out_q <= bus.data;
        rd_err_q   <= 1'b0;
      end else if (written_q[bus.address_read]) begin
        data_out_q <= mem_q[bus.address_read];
        rd_err_q   <= 1'b0;
      end else begin
        data_out_q <= '0;
        rd_err_q   <= 1'b1;
      end
    end else begin
      valid_out_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.wr_count  = wr_count_q;

endmodule
